// File: rtl/gate_4_pkg.sv
// Shared constants for the gate_4 block: default pipeline shape and the
// value every flop in the block takes while reset is asserted.
package gate_4_pkg;

    // Default number of synchronizer flops in front of each operand.
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Default output mode: 1 registers the gate results, 0 drives them
    // straight from the synchronized operands.
    localparam int REG_OUT_DEFAULT = 1;

    // Value loaded into every synchronizer and output flop during reset.
    localparam logic RESET_VAL = 1'b0;

endpackage : gate_4_pkg

// File: rtl/gate_4_sync.sv
// Single-bit synchronizer with asynchronous clear. STAGES flops long;
// STAGES = 0 turns the block into a plain wire.
module gate_4_sync
    import gate_4_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] chain;

            // Shift the raw input down the chain one flop per edge; reset clears every stage at once.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    chain <= {STAGES{RESET_VAL}};
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule : gate_4_sync

// File: rtl/gate_4.sv
// Four-input AND / OR gate with per-input synchronizers and an optional
// output register. All four operands share one pipeline depth, so inputs
// that change together reach the gates together.
module gate_4
    import gate_4_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int REG_OUT     = REG_OUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_y1,
    output logic o_y2
);

    logic sa;
    logic sb;
    logic sc;
    logic sd;
    logic and_comb;
    logic or_comb;

    gate_4_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_a),
        .q     (sa)
    );

    gate_4_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_b),
        .q     (sb)
    );

    gate_4_sync #(.STAGES(SYNC_STAGES)) u_sync_c (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_c),
        .q     (sc)
    );

    gate_4_sync #(.STAGES(SYNC_STAGES)) u_sync_d (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_d),
        .q     (sd)
    );

    // Gate logic on the synchronized operands.
    always_comb begin
        and_comb = sa & sb & sc & sd;
        or_comb  = sa | sb | sc | sd;
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic y1_q;
            logic y2_q;

            // Register both results on the same edge so they always update together.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    y1_q <= RESET_VAL;
                    y2_q <= RESET_VAL;
                end else begin
                    y1_q <= and_comb;
                    y2_q <= or_comb;
                end
            end

            assign o_y1 = y1_q;
            assign o_y2 = y2_q;
        end else begin : g_comb_out
            assign o_y1 = and_comb;
            assign o_y2 = or_comb;
        end
    endgenerate

endmodule : gate_4

// File: tb/tb_gate_4.sv
// Bench for gate_4: a default instance (3-clock latency) checked against a
// delay-line reference model, plus a SYNC_STAGES=0 / REG_OUT=0 instance
// checked against the plain truth table.
`timescale 1ns/1ps
module tb_gate_4;

    localparam int LAT = 3;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic d;
    logic y1;
    logic y2;
    logic y1_comb;
    logic y2_comb;

    int checks;
    int errors;

    // Input vectors seen on the most recent LAT edges, newest first.
    logic [3:0] hist [LAT] = '{default: 4'b0000};

    gate_4 u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_a   (a),
        .i_b   (b),
        .i_c   (c),
        .i_d   (d),
        .o_y1  (y1),
        .o_y2  (y2)
    );

    gate_4 #(.SYNC_STAGES(0), .REG_OUT(0)) u_comb (
        .i_clk (clk),
        .i_rst (rst),
        .i_a   (a),
        .i_b   (b),
        .i_c   (c),
        .i_d   (d),
        .o_y1  (y1_comb),
        .o_y2  (y2_comb)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: output reflects the inputs present LAT edges ago; reset forgets everything.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) hist[i] = 4'b0000;
        end else begin
            for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {a, b, c, d};
        end
    end

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got y1y2=%b, expected y1y2=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareModel();
        logic [3:0] old_v;
        logic [3:0] now_v;
        old_v = hist[LAT-1];
        now_v = {a, b, c, d};
        checkOutput("model", {y1, y2}, {(old_v == 4'b1111), (old_v != 4'b0000)});
        checkOutput("comb", {y1_comb, y2_comb}, {(now_v == 4'b1111), (now_v != 4'b0000)});
    endtask

    task automatic stepCycle();
        @(negedge clk);
        compareModel();
    endtask

    task automatic applyStimulus(input logic [3:0] v, input int cycles);
        {a, b, c, d} = v;
        repeat (cycles) stepCycle();
    endtask

    initial begin
        logic [3:0] rv;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        {a, b, c, d} = 4'b1111;
        #2;
        checkOutput("reset_dut", {y1, y2}, 2'b00);
        @(negedge clk);
        checkOutput("reset_hold", {y1, y2}, 2'b00);
        {a, b, c, d} = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b0000, 5);

        // Asynchronous reset with all inputs high.
        $display("[TB] async reset with 1111");
        applyStimulus(4'b1111, 6);
        checkOutput("ones_settled", {y1, y2}, 2'b11);
        #2 rst = 1'b1;
        #1 checkOutput("rst_async", {y1, y2}, 2'b00);
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("rst_release_e1", {y1, y2}, 2'b00);
        stepCycle();
        checkOutput("rst_release_e2", {y1, y2}, 2'b00);
        stepCycle();
        checkOutput("rst_release_e3", {y1, y2}, 2'b11);

        // Exhaustive truth-table sweep.
        $display("[TB] sweep 0000..1111");
        for (int v = 0; v < 16; v++) begin
            rv = v[3:0];
            applyStimulus(rv, 10);
            checkOutput("sweep", {y1, y2}, {(v == 15), (v != 0)});
        end

        // Latency 0000 -> 0001.
        $display("[TB] latency check");
        applyStimulus(4'b0000, 10);
        {a, b, c, d} = 4'b0001;
        stepCycle();
        checkOutput("lat_e1", {y1, y2}, 2'b00);
        stepCycle();
        checkOutput("lat_e2", {y1, y2}, 2'b00);
        stepCycle();
        checkOutput("lat_e3", {y1, y2}, 2'b01);

        // Simultaneous change 0111 -> 1000.
        $display("[TB] simultaneous change");
        applyStimulus(4'b0111, 10);
        {a, b, c, d} = 4'b1000;
        repeat (6) begin
            @(posedge clk);
            #1 checkOutput("simul_rise", {y1, y2}, 2'b01);
            stepCycle();
            checkOutput("simul_fall", {y1, y2}, 2'b01);
        end

        // Reset pulsed while 1111 is in flight.
        $display("[TB] mid-pipeline reset");
        applyStimulus(4'b0000, 10);
        {a, b, c, d} = 4'b1111;
        stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("midrst_in", {y1, y2}, 2'b00);
        rst = 1'b0;
        stepCycle();
        checkOutput("midrst_e1", {y1, y2}, 2'b00);
        stepCycle();
        checkOutput("midrst_e2", {y1, y2}, 2'b00);
        stepCycle();
        checkOutput("midrst_e3", {y1, y2}, 2'b11);

        // Randomized traffic with occasional asynchronous reset pulses.
        $display("[TB] random traffic");
        repeat (200) begin
            rv = 4'($urandom_range(0, 15));
            applyStimulus(rv, $urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) begin
                #3 rst = 1'b1;
                #1 checkOutput("rand_rst", {y1, y2}, 2'b00);
                stepCycle();
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gate_4

// File: doc/gate_4.md
GATE_4 -- requirements
Module: gate_4

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops per input; legal range 0..4, where 0 bypasses synchronization.
REQ-002 Parameter REG_OUT, default 1, selects output mode: 1 = registered outputs, 0 = combinational from the synchronized inputs.
REQ-003 i_clk  input  1  the single clock; all flops are rising-edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_a  input  1  logic operand A, may be asynchronous (switch or pin).
REQ-006 i_b  input  1  logic operand B, may be asynchronous.
REQ-007 i_c  input  1  logic operand C, may be asynchronous.
REQ-008 i_d  input  1  logic operand D, may be asynchronous.
REQ-009 o_y1  output  1  4-input AND result.
REQ-010 o_y2  output  1  4-input OR result.

Function
REQ-011 Each input shall pass through its own SYNC_STAGES-deep flop chain, giving sa, sb, sc, sd.
REQ-012 The AND result shall be o_y1 = sa AND sb AND sc AND sd.
REQ-013 The OR result shall be o_y2 = sa OR sb OR sc OR sd.
REQ-014 With REG_OUT=1, latency from an input change to the output shall be exactly SYNC_STAGES+1 rising edges; with REG_OUT=0 it shall be SYNC_STAGES edges.
REQ-015 With defaults, latency shall be 3 clocks.
REQ-016 Simultaneous changes on several inputs in the same cycle shall appear together at the outputs in the same cycle, with no intermediate combination visible.
REQ-017 An input pulse shorter than one clock period may be lost; this is accepted behaviour.
REQ-018 The block shall have no handshake and no state beyond the pipeline flops.
REQ-019 All 16 input combinations shall be supported.
REQ-020 o_y1 shall be 1 only for input 1111.
REQ-021 o_y2 shall be 0 only for input 0000.

Reset
REQ-022 Asserting i_rst shall immediately clear all synchronizer and output flops to 0, regardless of i_clk.
REQ-023 During reset, o_y1 = 0 and o_y2 = 0; with REG_OUT=0 this holds because the synchronizer flops are cleared.
REQ-024 After i_rst deasserts, outputs shall reflect the held inputs after the REQ-014 latency.
REQ-025 Reset asserted mid-pipeline shall discard all in-flight values.
REQ-026 No output glitch to 1 shall occur on reset release.

Structure
REQ-027 Package gate_4_pkg shall hold the SYNC_STAGES and REG_OUT default constants.
REQ-028 Package gate_4_pkg shall hold the reset-value constant (1'b0).
REQ-029 One sub-module, gate_4_sync, shall implement a single-bit parameterized synchronizer with asynchronous clear.
REQ-030 gate_4 shall instantiate gate_4_sync four times, once per input.
REQ-031 The top level shall hold only the gate logic and the optional output register.

Verification
REQ-032 Reset: assert i_rst with inputs 1111 -> o_y1=0 and o_y2=0 immediately, without waiting for a clock edge.
REQ-033 Exhaustive sweep: step inputs 0000 through 1111, holding each at least 10 clocks -> o_y1=1 only at 1111, and o_y2=0 only at 0000.
REQ-034 Latency: change inputs from 0000 to 0001 at a known edge -> o_y2 rises exactly 3 edges later with defaults, and not earlier.
REQ-035 Simultaneous change: inputs 0111 to 1000 in one cycle -> o_y2 stays 1 throughout and o_y1 stays 0, with no transient.
REQ-036 Mid-pipeline reset: apply 1111, then pulse i_rst one cycle later -> outputs remain 0 until the full latency elapses after reset release.
REQ-037 Parameter corner: SYNC_STAGES=0 with REG_OUT=0 -> outputs follow the inputs combinationally, with the same truth table.
